// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract sequencer.
package serial_add_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold WIDTH itself after the last bit, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake plus operand and result bus of the serial adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             C_out;
    logic             V;

    modport master (
        output start, sub, A, B,
        input  busy, done, Y, C_out, V
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, Y, C_out, V
    );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell; the only arithmetic in the serial datapath.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: shifts operands LSB first through one
// shared full-adder slice and publishes Y/C_out/V when the last bit is done.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one bit pair per clock through the slice
//   DONE  | result valid, done pulses; start here restarts at once
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             v_q, v_d;
    logic             fa_s, fa_c;

    serial_add_ctrl_fa u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        y_d     = y_q;
        count_d = count_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        v_d     = v_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
                    opa_d   = bus.A;
                    opb_d   = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub;
                    res_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_c;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    // On the MSB cycle carry_q is the carry into the MSB.
                    y_d     = {fa_s, res_q[WIDTH-1:1]};
                    c_out_d = fa_c;
                    v_d     = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            y_q     <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            y_q     <= y_d;
            count_q <= count_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            v_q     <= v_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.Y     = y_q;
    assign bus.C_out = c_out_q;
    assign bus.V     = v_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer that shares a single one-bit full-adder slice across a WIDTH-bit operation. It latches two operands on a start request and feeds one bit pair per clock through the slice, LSB first, holding the carry in a flip-flop between cycles. It presents the WIDTH-bit result with carry and overflow flags under a start/busy/done handshake. It sits beside the processor's ALU as the area-minimal arithmetic path for multi-cycle instructions.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled on rising clk edge.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- A  input  WIDTH  first operand; sampled with start.
- B  input  WIDTH  second operand; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result valid.
- Y  output  WIDTH  result; held until the next accepted start.
- C_out  output  1  carry out of MSB (subtract: 1 = no borrow).
- V  output  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: load opA←A, opB←(sub ? ~B : B), carry←sub, result←0, count←0; next state is RUN.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN, each cycle: slice computes s = opA[0]^opB[0]^carry, c = maj(opA[0],opB[0],carry).
  - Update: result←{s, result[WIDTH-1:1]}; opA, opB shift right by 1 (zero fill); carry←c; count←count+1.
  - When count = WIDTH−1: also capture cmsb_in←carry (the carry into the MSB).
  - When count = WIDTH−1, next state is DONE.
- Entering DONE: Y←final result, C_out←final carry, V←cmsb_in ^ final carry.
- Y, C_out and V are registered. They change only on the DONE-entry edge and hold through IDLE.
- start while in RUN: ignored; no queueing and no effect on the operation in flight.
- start in the DONE cycle: accepted. The operation restarts with no IDLE gap; done pulses once per operation.
- count width: clog2(WIDTH)+1 bits. No wrap-around within an operation.

## Timing
- Reset values, all outputs and state: state=IDLE, busy=0, done=0, Y=0, C_out=0, V=0. Internal registers are also 0.
- Reset mid-RUN aborts immediately. No done pulse; Y returns to 0.
- start sampled at edge k. busy=1 for cycles k+1 … k+WIDTH. done=1 in cycle k+WIDTH+1 only.
- Latency start→done: WIDTH+1 cycles. Throughput: one operation per WIDTH+1 cycles.
- Y/C_out/V are valid in the same cycle done is high.
- busy is a decode of state==RUN. done is a decode of state==DONE. Neither output has combinational paths from inputs.

## Structure
- Shared package: state enum (IDLE, RUN, DONE), state width constant, and a count-width helper (clog2).
- One sub-module: the existing one-bit full-adder cell, instantiated once as the shared datapath slice. The controller holds only the registers, counter and FSM around it.

## Test plan
- WIDTH=8, A=0x35, B=0x4A, sub=0 → Y=0x7F, C_out=0, V=0. done exactly 9 cycles after the start edge; busy high for 8 cycles.
- A=0xFF, B=0x01, sub=0 → Y=0x00, C_out=1, V=0. Then A=0x7F, B=0x01 → Y=0x80, C_out=0, V=1.
- A=0x10, B=0x20, sub=1 → Y=0xF0, C_out=0 (borrow), V=0. Then A=0x80, B=0x01, sub=1 → Y=0x7F, C_out=1, V=1.
- Start A=0x01, B=0x02, then pulse start with A=0xAA mid-RUN → ignored; Y=0x03, single done. Start on the done cycle with A=0x05, B=0x05 → next done 9 cycles later, Y=0x0A.
- Assert rst in the 4th RUN cycle of A=0x35+0x4A → busy, done, Y, C_out, V all 0 immediately. No done pulse; FSM in IDLE; next start completes normally.
